// File: rtl/hash_unround.sv
// Sequential inverse of the 8-bit hash round: recovers the initial state from a final state and message, one round per clock.
// Optional HASH_UNROUND_CHECK_EN adds expect_state/match for comparing the recovered state against an expected value.
module hash_unround #(
  parameter int unsigned NUM_ROUNDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_state,
  input  logic [63:0] in_msg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_state
`ifdef HASH_UNROUND_CHECK_EN
  ,
  input  logic [31:0] expect_state,
  output logic        match
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] work_q;
  logic [63:0] msg_q;
  logic [2:0]  round_q;
`ifdef HASH_UNROUND_CHECK_EN
  logic [31:0] expect_q;
  logic        match_q;
`endif

  logic [7:0]  c_w, b_w, d_w, x_w, mix_w, a_w, byte_w;
  logic [15:0] rot_w;
  logic [31:0] work_d;

  // Inverse of round round_q applied to the working register.
  always_comb begin
    c_w    = work_q[31:24];
    b_w    = work_q[23:16];
    d_w    = work_q[7:0];
    rot_w  = {work_q[15:8], work_q[15:8]} >> round_q;
    x_w    = rot_w[7:0];
    byte_w = msg_q[{round_q, 3'b000} +: 8];
    case (round_q)
      3'd0, 3'd1, 3'd2: mix_w = (c_w & b_w) | (~b_w & d_w);
      3'd3, 3'd4:       mix_w = (c_w & b_w) | (b_w & d_w) | (d_w & c_w);
      default:          mix_w = c_w ^ b_w ^ d_w;
    endcase
    a_w    = x_w - mix_w - byte_w;
    work_d = {d_w, c_w, b_w, a_w};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      work_q      <= '0;
      msg_q       <= '0;
      round_q     <= '0;
`ifdef HASH_UNROUND_CHECK_EN
      expect_q    <= '0;
      match_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= in_state;
            msg_q      <= in_msg;
            round_q    <= 3'(NUM_ROUNDS - 1);
            in_ready_q <= 1'b0;
            state_q    <= RUN;
`ifdef HASH_UNROUND_CHECK_EN
            expect_q   <= expect_state;
`endif
          end
        end
        RUN: begin
          work_q <= work_d;
          if (round_q == 3'd0) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef HASH_UNROUND_CHECK_EN
            match_q     <= (work_d == expect_q);
`endif
          end else begin
            round_q <= round_q - 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
`ifdef HASH_UNROUND_CHECK_EN
            match_q     <= 1'b0;
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = work_q;
`ifdef HASH_UNROUND_CHECK_EN
  assign match     = match_q;
`endif

endmodule

// File: tb/tb_hash_unround.sv
// Scoreboard bench for hash_unround: a one-round and an eight-round instance checked against a forward hash model.
module tb_hash_unround;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] st;
    logic        mt;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  int   acc8[$];

  logic        rst1, iv1, ir1, ov1, or1;
  logic [31:0] st1, os1;
  logic [63:0] msg1;
  logic        rst8, iv8, ir8, ov8, or8;
  logic [31:0] st8, os8;
  logic [63:0] msg8;
`ifdef HASH_UNROUND_CHECK_EN
  logic [31:0] es1, es8;
  logic        m1, m8;
`endif

  hash_unround #(.NUM_ROUNDS(1)) u1 (
    .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1), .in_state(st1), .in_msg(msg1),
    .out_valid(ov1), .out_ready(or1), .out_state(os1)
`ifdef HASH_UNROUND_CHECK_EN
    , .expect_state(es1), .match(m1)
`endif
  );

  hash_unround #(.NUM_ROUNDS(8)) u8 (
    .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8), .in_state(st8), .in_msg(msg8),
    .out_valid(ov8), .out_ready(or8), .out_state(os8)
`ifdef HASH_UNROUND_CHECK_EN
    , .expect_state(es8), .match(m8)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Forward model: round r on {d,c,b,a} gives {c,b,rotl(mix+a+byte,r),d}.
  function automatic logic [31:0] fwd_round(input logic [31:0] s, input int r, input logic [7:0] mb);
    logic [7:0]  a, b, c, d, mx, x;
    logic [15:0] dbl;
    a = s[7:0]; b = s[15:8]; c = s[23:16]; d = s[31:24];
    if (r <= 2)      mx = (c & b) | (~b & d);
    else if (r <= 4) mx = (c & b) | (b & d) | (d & c);
    else             mx = c ^ b ^ d;
    x   = mx + a + mb;
    dbl = {x, x} << r;
    return {c, b, dbl[15:8], d};
  endfunction

  function automatic logic [31:0] fwd(input logic [31:0] s, input logic [63:0] m, input int n);
    logic [31:0] t;
    t = s;
    for (int r = 0; r < n; r++) t = fwd_round(t, r, m[8*r +: 8]);
    return t;
  endfunction

  exp_t e1, e8;
  logic ov8_prev = 1'b0;

  always @(negedge clk) begin
    if (rst1) q1.delete();
    else if (ov1 && or1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_unexpected: got out_state %h expected no output", os1);
      end else begin
        e1 = q1.pop_front();
        chk("u1_state", os1, e1.st);
`ifdef HASH_UNROUND_CHECK_EN
        chk("u1_match", {31'b0, m1}, {31'b0, e1.mt});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst8) begin
      q8.delete();
      acc8.delete();
      ov8_prev = 1'b0;
    end else begin
      if (ov8 && !ov8_prev) begin
        if (acc8.size() == 0) begin
          checks++; errors++;
          $display("FAIL u8_spurious_valid: got out_valid rise at cycle %0d expected none", cyc);
        end else chk("u8_latency", cyc - acc8.pop_front(), 8);
      end
      if (ov8 && or8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL u8_unexpected: got out_state %h expected no output", os8);
        end else begin
          e8 = q8.pop_front();
          chk("u8_state", os8, e8.st);
`ifdef HASH_UNROUND_CHECK_EN
          chk("u8_match", {31'b0, m8}, {31'b0, e8.mt});
`endif
        end
      end
      ov8_prev = ov8;
    end
  end

  task automatic send1(input logic [31:0] s, input logic [63:0] m, input logic [31:0] exp,
                       input logic [31:0] es);
    int n;
    @(posedge clk); #1;
    st1 = s; msg1 = m; iv1 = 1'b1;
`ifdef HASH_UNROUND_CHECK_EN
    es1 = es;
`endif
    n = 0;
    @(negedge clk);
    while (!ir1 && n < 50) begin @(negedge clk); n++; end
    if (!ir1) begin
      checks++; errors++;
      $display("FAIL u1_accept_timeout: got in_ready 0 expected 1");
      iv1 = 1'b0;
    end else begin
      q1.push_back('{exp, (exp == es)});
      @(posedge clk); #1;
      iv1 = 1'b0; st1 = ~s; msg1 = ~m;
`ifdef HASH_UNROUND_CHECK_EN
      es1 = ~es;
`endif
      @(negedge clk); chk("u1_valid_run", {31'b0, ov1}, 0);
      @(negedge clk); chk("u1_valid_done", {31'b0, ov1}, 1);
    end
  endtask

  task automatic send8(input logic [31:0] orig, input logic [63:0] m, input bit hold, output int acc);
    int n;
    @(posedge clk); #1;
    st8 = fwd(orig, m, 8); msg8 = m; iv8 = 1'b1;
`ifdef HASH_UNROUND_CHECK_EN
    es8 = orig;
`endif
    n = 0;
    @(negedge clk);
    while (!ir8 && n < 100) begin @(negedge clk); n++; end
    if (!ir8) begin
      checks++; errors++;
      $display("FAIL u8_accept_timeout: got in_ready 0 expected 1");
      iv8 = 1'b0;
      acc = -1;
    end else begin
      acc = cyc + 1;
      q8.push_back('{orig, 1'b1});
      acc8.push_back(acc);
      @(posedge clk); #1;
      if (!hold) begin
        iv8 = 1'b0; st8 = ~st8; msg8 = ~m;
`ifdef HASH_UNROUND_CHECK_EN
        es8 = ~orig;
`endif
      end
    end
  endtask

  task automatic drain8();
    int n;
    n = 0;
    while (q8.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("u8_drain", q8.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] s, orig;
    logic [63:0] m;
    int a, prev, seen, n;

    rst1 = 1'b1; rst8 = 1'b1; iv1 = 1'b0; iv8 = 1'b0; or1 = 1'b1; or8 = 1'b1;
    st1 = '0; st8 = '0; msg1 = '0; msg8 = '0;
`ifdef HASH_UNROUND_CHECK_EN
    es1 = '0; es8 = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("u1_rst_ready", {31'b0, ir1}, 1);
    chk("u1_rst_valid", {31'b0, ov1}, 0);
    chk("u1_rst_state", os1, 0);
    chk("u8_rst_ready", {31'b0, ir8}, 1);
    chk("u8_rst_valid", {31'b0, ov8}, 0);
    chk("u8_rst_state", os8, 0);
`ifdef HASH_UNROUND_CHECK_EN
    chk("u8_rst_match", {31'b0, m8}, 0);
`endif
    @(posedge clk); #1;
    rst1 = 1'b0; rst8 = 1'b0;

    // Hand-computed single-round vectors; upper message bytes must not matter.
    send1(32'h12345678, 64'h0000_0000_0000_0001, 32'h781234FD, 32'h781234FD);
    send1(32'h12345678, 64'hA5A5_A5A5_A5A5_A501, 32'h781234FD, 32'h781234FC);
    send1(32'hFFFFFFFF, 64'h0000_0000_0000_00FF, 32'hFFFFFF01, 32'hFFFFFF01);
    send1(32'h00000000, 64'h0000_0000_0000_0000, 32'h00000000, 32'h00000001);

    for (int i = 0; i < 16; i++) begin
      s = $urandom;
      m = {$urandom, $urandom};
      send8(s, m, 1'b0, a);
    end
    drain8();

    // Hold the result with out_ready low; an in_valid pulse meanwhile must be ignored.
    or8 = 1'b0;
    orig = 32'hCAFE0123;
    send8(orig, 64'h0123_4567_89AB_CDEF, 1'b0, a);
    n = 0;
    while (!ov8 && n < 30) begin @(negedge clk); n++; end
    chk("u8_hold_valid_seen", {31'b0, ov8}, 1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        @(posedge clk); #1;
        st8 = 32'hDEADBEEF; msg8 = 64'hFFFF_0000_FFFF_0000; iv8 = 1'b1;
      end
      if (k == 3) begin
        @(posedge clk); #1;
        iv8 = 1'b0;
      end
      @(negedge clk);
      chk("u8_hold_valid", {31'b0, ov8}, 1);
      chk("u8_hold_state", os8, orig);
      chk("u8_hold_ready", {31'b0, ir8}, 0);
`ifdef HASH_UNROUND_CHECK_EN
      chk("u8_hold_match", {31'b0, m8}, 1);
`endif
    end
    @(posedge clk); #1;
    or8 = 1'b1;
    send8(32'h5A5AA5A5, 64'h1122_3344_5566_7788, 1'b0, a);
    drain8();

    // Abort in RUN with round 4 pending.
    send8(32'h0BADF00D, 64'h8877_6655_4433_2211, 1'b0, a);
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(negedge clk);
    chk("u8_abort_ready", {31'b0, ir8}, 1);
    chk("u8_abort_valid", {31'b0, ov8}, 0);
    chk("u8_abort_state", os8, 0);
`ifdef HASH_UNROUND_CHECK_EN
    chk("u8_abort_match", {31'b0, m8}, 0);
`endif
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    chk("u8_abort_no_output", seen, 0);

    // Back-to-back with in_valid and out_ready held high.
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      s = 32'h1000_0001 * (i + 3);
      m = {32'h9E37_79B9 * (i + 1), 32'h7F4A_7C15 ^ i};
      send8(s, m, 1'b1, a);
      if (i > 0) chk("u8_b2b_interval", a - prev, 10);
      prev = a;
    end
    iv8 = 1'b0;

    n = 0;
    while ((q1.size() != 0 || q8.size() != 0) && n < 200) begin @(negedge clk); n++; end
    chk("final_drain", q1.size() + q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
